spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
- Synthesizable SPI flash slave model. It is the far end of the SoC's XIP flash master (flash_CS/sck_o/mosi_o).
- Replaces the testbench MOSI→MISO loopback so boot and XIP fetch see real flash behaviour.
- Oversamples SPI mode 0 on the system clock.
- Byte data comes from an external synchronous memory port (ROM or BRAM image).

Parameters:
- ADDR_W, 24, memory address width; address wraps modulo 2^ADDR_W.
- JEDEC_ID, 24'hEF4017, bytes returned by 0x9F, MSB byte first.
- STATUS, 8'h00, value returned by 0x05.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- cs_n_i  in  1  chip select, active-low
- sck_i  in  1  SPI clock; period ≥ 8 clk_i
- mosi_i  in  1  serial data in
- miso_o  out  1  serial data out
- miso_oe_o  out  1  MISO drive enable
- mem_addr_o  out  ADDR_W  byte address to memory
- mem_rd_o  out  1  one-cycle read strobe
- mem_data_i  in  8  read data, valid the clk_i after mem_rd_o
- cmd_o  out  8  last decoded opcode
- cmd_valid_o  out  1  one-cycle pulse when opcode byte completes

Behaviour:
- Reset values: miso_o=0, miso_oe_o=0, mem_rd_o=0, mem_addr_o=0, cmd_o=0, cmd_valid_o=0; state IDLE.
- Synchronisation:
  - cs_n_i, sck_i and mosi_i pass through 2-FF synchronisers.
  - Rise/fall of SCK is detected from the synchronised value plus one history FF.
  - Edge detect latency is 3 clk_i.
- Protocol: SPI mode 0, MSB first.
  - MOSI is sampled on a detected SCK rise.
  - miso_o changes only on a detected SCK fall, or at the first SCK fall after the data phase begins.
- CS high (synchronised) in any state: go to IDLE, clear the bit counter, miso_oe_o=0, miso_o=0. This takes priority over a same-cycle SCK edge.
- IDLE: on CS low go to CMD, bit counter=0.
- CMD: shift 8 bits. On the 8th rise:
  - cmd_o=opcode, cmd_valid_o=1 for one cycle.
  - 0x03 → ADDR (no dummy).
  - 0x0B → ADDR (dummy flag set).
  - 0x9F → ID.
  - 0x05 → STAT.
  - Any other opcode → IGNORE.
- ADDR: shift 24 bits into the address register; the low ADDR_W bits are used. On the 24th rise:
  - If dummy flag is set → DUMMY.
  - Otherwise mem_rd_o=1 with mem_addr_o=addr, then → DATA.
- DUMMY: count 8 rises, then issue mem_rd_o and go to DATA.
- DATA:
  - The shift register loads mem_data_i on the cycle after mem_rd_o.
  - miso_oe_o=1 from entry.
  - Each SCK fall drives the next bit, MSB first.
  - On the 8th rise of each byte: addr=addr+1 (wraps 2^ADDR_W−1→0) and a new mem_rd_o is issued, so the next byte is ready before the next fall.
  - Reads continue indefinitely until CS goes high.
- ID: emits JEDEC_ID[23:16], then [15:8], then [7:0], then 0x00 for every further byte. miso_oe_o=1.
- STAT: emits STATUS repeatedly. miso_oe_o=1.
- IGNORE: miso_oe_o=0 and mosi_i is ignored until CS goes high.
- CS low for fewer than 8 rises: no cmd_valid_o, no memory access.
- Reset mid-transfer: immediate return to reset values. A new transfer requires CS high→low after reset deasserts.
- SCK faster than clk_i/8 is unsupported; behaviour is undefined.

Test Plan:
- Read: memory byte[n]=n[7:0]. Send 0x03, addr 0x000010, clock 4 bytes → miso 0x10,0x11,0x12,0x13. mem_addr_o steps 0x10→0x14. cmd_o=0x03 with a single cmd_valid_o pulse.
- Fast read with wrap, ADDR_W=8: send 0x0B, addr 0x0000FE, 8 dummy clocks, 3 bytes → 0xFE,0xFF,0x00. miso_oe_o is 0 during dummy clocks and 1 from the first data fall.
- JEDEC ID: send 0x9F, 5 bytes → 0xEF,0x40,0x17,0x00,0x00. Status: send 0x05, 2 bytes → 0x00,0x00.
- Unknown opcode: send 0xAB + 16 clocks → miso_oe_o stays 0, mem_rd_o never asserted, cmd_o=0xAB.
- Abort: CS high after 12 address bits of 0x03. Next transfer 0x03 addr 0x000020 → data 0x20; no residual shift state.
- Async reset: assert rst_i mid-DATA (clock low, between edges) → miso_oe_o=0 and miso_o=0 in the same cycle. After release with CS low, no output until CS toggles high→low.

Source files
------------

// File: rtl/spi_flash_responder_if.sv
// SPI pins plus the byte-wide memory read port of the flash responder.
// The slave modport is the responder; the master modport is the host/memory side.
interface spi_flash_responder_if #(
  parameter int ADDR_W = 24
);
  logic              cs_n_i;
  logic              sck_i;
  logic              mosi_i;
  logic              miso_o;
  logic              miso_oe_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_rd_o;
  logic [7:0]        mem_data_i;
  logic [7:0]        cmd_o;
  logic              cmd_valid_o;

  modport slave (
    input  cs_n_i, sck_i, mosi_i, mem_data_i,
    output miso_o, miso_oe_o, mem_addr_o, mem_rd_o, cmd_o, cmd_valid_o
  );

  modport master (
    output cs_n_i, sck_i, mosi_i, mem_data_i,
    input  miso_o, miso_oe_o, mem_addr_o, mem_rd_o, cmd_o, cmd_valid_o
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI flash slave (mode 0, oversampled on clk_i) answering READ, FAST READ,
// JEDEC ID and READ STATUS, with data fetched from a synchronous byte memory.
module spi_flash_responder #(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4017,
  parameter logic [7:0]  STATUS   = 8'h00
) (
  input logic               clk_i,
  input logic               rst_i,
  spi_flash_responder_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_STAT, S_IGNORE
  } state_e;

  logic cs_meta_q, cs_q, sck_meta_q, sck_q, sck_hist_q, mosi_meta_q, mosi_q;
  logic sck_rise, sck_fall;

  state_e            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              rd_pend_q, rd_pend_d;
  logic [7:0]        tx_q, tx_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              dummy_q, dummy_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic              armed_q, armed_d;
  logic [7:0]        opcode;

  // CS sync resets to "selected" so a CS held low across reset never arms;
  // a real high->low transition is needed before the next command.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_meta_q   <= 1'b0;
      cs_q        <= 1'b0;
      sck_meta_q  <= 1'b0;
      sck_q       <= 1'b0;
      sck_hist_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      cs_meta_q   <= bus.cs_n_i;
      cs_q        <= cs_meta_q;
      sck_meta_q  <= bus.sck_i;
      sck_q       <= sck_meta_q;
      sck_hist_q  <= sck_q;
      mosi_meta_q <= bus.mosi_i;
      mosi_q      <= mosi_meta_q;
    end
  end

  assign sck_rise = sck_q & ~sck_hist_q;
  assign sck_fall = ~sck_q & sck_hist_q;
  assign opcode   = {shift_q, mosi_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_sh_q   <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      dummy_q     <= 1'b0;
      id_idx_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_sh_q   <= addr_sh_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      rd_pend_q   <= rd_pend_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      dummy_q     <= dummy_d;
      id_idx_q    <= id_idx_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_sh_d   = addr_sh_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    rd_pend_d   = mem_rd_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    dummy_d     = dummy_q;
    id_idx_d    = id_idx_q;
    armed_d     = armed_q | cs_q;

    // Memory data arrives the cycle after the strobe, well before the next fall.
    if (rd_pend_q) tx_d = mem_data_i_w();

    if (cs_q) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      miso_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (armed_q) begin
            state_d   = S_CMD;
            bit_cnt_d = '0;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            shift_d   = opcode[6:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d   = '0;
              cmd_d       = opcode;
              cmd_valid_d = 1'b1;
              dummy_d     = 1'b0;
              case (opcode)
                8'h03: state_d = S_ADDR;
                8'h0B: begin state_d = S_ADDR; dummy_d = 1'b1; end
                8'h9F: begin
                  state_d  = S_ID;
                  tx_d     = JEDEC_ID[23:16];
                  id_idx_d = 2'd1;
                  oe_d     = 1'b1;
                end
                8'h05: begin state_d = S_STAT; tx_d = STATUS; oe_d = 1'b1; end
                default: state_d = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            // Only the low ADDR_W bits survive 24 shifts, giving the modulo wrap.
            addr_sh_d = {addr_sh_q[ADDR_W-2:0], mosi_q};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d  = '0;
              mem_addr_d = {addr_sh_q[ADDR_W-2:0], mosi_q};
              if (dummy_q) begin
                state_d = S_DUMMY;
              end else begin
                state_d  = S_DATA;
                mem_rd_d = 1'b1;
                oe_d     = 1'b1;
              end
            end
          end
        end
        S_DUMMY: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              state_d   = S_DATA;
              mem_rd_d  = 1'b1;
              oe_d      = 1'b1;
            end
          end
        end
        S_DATA, S_ID, S_STAT: begin
          if (sck_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              if (state_q == S_DATA) begin
                mem_addr_d = mem_addr_q + 1'b1;
                mem_rd_d   = 1'b1;
              end else if (state_q == S_STAT) begin
                tx_d = STATUS;
              end else begin
                case (id_idx_q)
                  2'd1:    begin tx_d = JEDEC_ID[15:8]; id_idx_d = 2'd2; end
                  2'd2:    begin tx_d = JEDEC_ID[7:0];  id_idx_d = 2'd3; end
                  default: tx_d = 8'h00;
                endcase
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [7:0] mem_data_i_w();
    return bus.mem_data_i;
  endfunction

  assign bus.miso_o      = miso_q;
  assign bus.miso_oe_o   = oe_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_rd_o    = mem_rd_q;
  assign bus.cmd_o       = cmd_q;
  assign bus.cmd_valid_o = cmd_valid_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Drives two responders (24-bit and 8-bit address) with the same SPI traffic;
// a monitor pops expected MISO bytes from per-device queues filled by the driver.
module tb_spi_flash_responder;
  localparam logic [23:0] JEDEC = 24'hEF4017;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] oe;
  } exp_t;

  logic clk, rst, cs_n, sck, mosi;
  int   checks = 0;
  int   errors = 0;
  exp_t q24[$];
  exp_t q8[$];
  int   rd_cnt24 = 0, rd_cnt8 = 0, cv_cnt24 = 0, cv_cnt8 = 0;
  logic [7:0] last_cmd;

  spi_flash_responder_if #(.ADDR_W(24)) if24();
  spi_flash_responder_if #(.ADDR_W(8))  if8();

  assign if24.cs_n_i = cs_n;
  assign if24.sck_i  = sck;
  assign if24.mosi_i = mosi;
  assign if8.cs_n_i  = cs_n;
  assign if8.sck_i   = sck;
  assign if8.mosi_i  = mosi;

  spi_flash_responder #(.ADDR_W(24), .JEDEC_ID(JEDEC), .STATUS(8'h00)) dut24 (
    .clk_i(clk), .rst_i(rst), .bus(if24));
  spi_flash_responder #(.ADDR_W(8), .JEDEC_ID(JEDEC), .STATUS(8'h5A)) dut8 (
    .clk_i(clk), .rst_i(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: a byte derived from the address (byte[n] = n for n < 256).
  function automatic logic [7:0] memf(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16];
  endfunction

  always @(posedge clk) begin
    if (if24.mem_rd_o) if24.mem_data_i <= memf(if24.mem_addr_o);
    if (if8.mem_rd_o)  if8.mem_data_i  <= memf({16'h0, if8.mem_addr_o});
    if (if24.mem_rd_o) rd_cnt24 <= rd_cnt24 + 1;
    if (if8.mem_rd_o)  rd_cnt8  <= rd_cnt8 + 1;
    if (if24.cmd_valid_o) cv_cnt24 <= cv_cnt24 + 1;
    if (if8.cmd_valid_o)  cv_cnt8  <= cv_cnt8 + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: which byte slot of a transaction carries what, for one device.
  function automatic int data_base(input logic [7:0] op);
    case (op)
      8'h03:        return 4;
      8'h0B:        return 5;
      8'h9F, 8'h05: return 1;
      default:      return 1000;
    endcase
  endfunction

  function automatic exp_t model(input int d, input logic [7:0] op,
                                 input logic [23:0] addr, input int k);
    exp_t        e;
    int          base;
    int unsigned a;
    logic [23:0] j;
    e    = '0;
    base = data_base(op);
    j    = JEDEC;
    if (k >= base) begin
      e.oe = 8'hFF;
      if (op == 8'h03 || op == 8'h0B) begin
        a = (d == 0) ? ((addr + k - base) % (1 << 24)) : ((addr + k - base) % 256);
        e.data = memf(a[23:0]);
      end else if (op == 8'h9F) begin
        e.data = (k <= 3) ? j[8*(3-k) +: 8] : 8'h00;
      end else begin
        e.data = (d == 0) ? 8'h00 : 8'h5A;
      end
    end
    return e;
  endfunction

  task automatic send_bit(input logic b);
    mosi = b;
    repeat (5) @(negedge clk);
    sck = 1'b1;
    repeat (5) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic push_exp(input logic [7:0] op, input logic [23:0] addr, input int fb);
    for (int k = 0; k < fb; k++) begin
      q24.push_back(model(0, op, addr, k));
      q8.push_back(model(1, op, addr, k));
    end
  endtask

  task automatic xfer(input logic [7:0] op, input logic [23:0] addr, input int nbits);
    logic [31:0] hdr;
    int fb, base, reads, rd0_24, rd0_8, cv0_24, cv0_8;
    int unsigned fa;
    fb     = nbits / 8;
    base   = data_base(op);
    hdr    = {op, addr};
    rd0_24 = rd_cnt24; rd0_8 = rd_cnt8; cv0_24 = cv_cnt24; cv0_8 = cv_cnt8;
    $display("xfer op=%02h addr=%06h bits=%0d", op, addr, nbits);
    push_exp(op, addr, fb);
    cs_low();
    for (int i = 0; i < nbits; i++) begin
      if (i < 8 || ((op == 8'h03 || op == 8'h0B) && i < 32)) send_bit(hdr[31-i]);
      else send_bit(1'($urandom_range(0, 1)));
    end
    cs_high();
    if (nbits >= 8) last_cmd = op;
    reads = (fb >= base && (op == 8'h03 || op == 8'h0B)) ? 1 + fb - base : 0;
    chk("cmd_valid_pulses dut24", cv_cnt24 - cv0_24, (nbits >= 8) ? 1 : 0);
    chk("cmd_valid_pulses dut8", cv_cnt8 - cv0_8, (nbits >= 8) ? 1 : 0);
    chk("cmd_o dut24", if24.cmd_o, last_cmd);
    chk("cmd_o dut8", if8.cmd_o, last_cmd);
    chk("mem_rd_pulses dut24", rd_cnt24 - rd0_24, reads);
    chk("mem_rd_pulses dut8", rd_cnt8 - rd0_8, reads);
    if (reads > 0) begin
      fa = addr + reads - 1;
      chk("mem_addr_end dut24", if24.mem_addr_o, fa % (1 << 24));
      chk("mem_addr_end dut8", if8.mem_addr_o, fa % 256);
    end
  endtask

  task automatic sb_pop(input int d, input logic [7:0] m, input logic [7:0] o);
    exp_t e;
    checks++;
    if ((d == 0 && q24.size() == 0) || (d == 1 && q8.size() == 0)) begin
      errors++;
      $display("FAIL sb_unexpected dut%0d: got data=%02h oe=%02h, required no byte", d, m, o);
    end else begin
      checks--;
      e = (d == 0) ? q24.pop_front() : q8.pop_front();
      chk($sformatf("sb_miso dut%0d", d), m, e.data);
      chk($sformatf("sb_oe dut%0d", d), o, e.oe);
    end
  endtask

  // Monitor: assembles one byte per 8 SCK rises while CS is low.
  initial begin : monitor
    int nb;
    logic [7:0] m24, o24, m8, o8;
    nb = 0;
    m24 = '0; o24 = '0; m8 = '0; o8 = '0;
    forever begin
      @(posedge sck or posedge cs_n or posedge rst);
      if (cs_n || rst) begin
        nb = 0;
      end else begin
        m24 = {m24[6:0], if24.miso_o};
        o24 = {o24[6:0], if24.miso_oe_o};
        m8  = {m8[6:0], if8.miso_o};
        o8  = {o8[6:0], if8.miso_oe_o};
        nb++;
        if (nb == 8) begin
          nb = 0;
          sb_pop(0, m24, o24);
          sb_pop(1, m8, o8);
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0]  op;
    logic [23:0] addr;
    rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    last_cmd = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset miso", {if24.miso_o, if8.miso_o}, 2'b00);
    chk("reset miso_oe", {if24.miso_oe_o, if8.miso_oe_o}, 2'b00);
    chk("reset mem_rd", {if24.mem_rd_o, if8.mem_rd_o}, 2'b00);
    chk("reset mem_addr", {if24.mem_addr_o, if8.mem_addr_o}, 32'h0);
    chk("reset cmd", {if24.cmd_o, if8.cmd_o}, 16'h0);
    chk("reset cmd_valid", {if24.cmd_valid_o, if8.cmd_valid_o}, 2'b00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    xfer(8'h03, 24'h000010, 8 * 8);
    xfer(8'h0B, 24'h0000FE, 8 * 8);
    xfer(8'h9F, 24'h0, 8 * 6);
    xfer(8'h05, 24'h0, 8 * 3);
    xfer(8'hAB, 24'h0, 8 + 16);
    xfer(8'h03, 24'($urandom), 8 + 12);
    xfer(8'h03, 24'h000020, 8 * 5);
    xfer(8'h03, 24'hFFFFFF, 8 * 6);
    xfer(8'h05, 24'h0, 5);

    for (int t = 0; t < 16; t++) begin
      case ($urandom_range(0, 4))
        0: op = 8'h03;
        1: op = 8'h0B;
        2: op = 8'h9F;
        3: op = 8'h05;
        default: begin
          op = 8'($urandom);
          while (op == 8'h03 || op == 8'h0B || op == 8'h9F || op == 8'h05) op = 8'($urandom);
        end
      endcase
      addr = 24'($urandom);
      xfer(op, addr, $urandom_range(4, 64));
    end

    // Reset in the middle of a data byte (SCK low), CS held low afterwards.
    $display("xfer op=03 addr=0000ff bits=34 then reset");
    push_exp(8'h03, 24'h0000FF, 4);
    cs_low();
    for (int i = 0; i < 34; i++) send_bit((i < 8) ? (i >= 6) : (i >= 24 && i < 32));
    repeat (4) @(negedge clk);
    chk("pre_reset miso_oe", {if24.miso_oe_o, if8.miso_oe_o}, 2'b11);
    chk("pre_reset miso", {if24.miso_o, if8.miso_o}, 2'b11);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_reset miso_oe", {if24.miso_oe_o, if8.miso_oe_o}, 2'b00);
    chk("async_reset miso", {if24.miso_o, if8.miso_o}, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_cmd = 8'h00;
    begin
      int rd0, cv0;
      rd0 = rd_cnt24 + rd_cnt8;
      cv0 = cv_cnt24 + cv_cnt8;
      for (int k = 0; k < 2; k++) begin
        q24.push_back('0);
        q8.push_back('0);
      end
      repeat (5) @(negedge clk);
      for (int i = 0; i < 16; i++) send_bit((i < 8) ? (i >= 6) : 1'b0);
      chk("post_reset cmd_valid", cv_cnt24 + cv_cnt8 - cv0, 0);
      chk("post_reset mem_rd", rd_cnt24 + rd_cnt8 - rd0, 0);
      chk("post_reset cmd", {if24.cmd_o, if8.cmd_o}, 16'h0);
    end
    cs_high();
    xfer(8'h05, 24'h0, 8 * 3);
    xfer(8'h03, 24'h000040, 8 * 5);

    chk("sb_leftover dut24", q24.size(), 0);
    chk("sb_leftover dut8", q8.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
